// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-N stream demultiplexer.
// A single valid/ready input stream is steered by i_in_sel into a one-entry
// output slot per channel; each channel drains under its own handshake.
// Optional broadcast mode is enabled by defining DEMUX_BCAST_EN, which adds
// the i_in_bcast port and lets one accepted word load every slot at once.
module demux_stream #(
   parameter int WIDTH = 8,
   parameter int SEL_W = 2
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_in_valid,
   output logic                        o_in_ready,
   input  logic [WIDTH-1:0]            i_in_data,
   input  logic [SEL_W-1:0]            i_in_sel,
`ifdef DEMUX_BCAST_EN
   input  logic                        i_in_bcast,
`endif
   output logic [(2**SEL_W)-1:0]       o_out_valid,
   input  logic [(2**SEL_W)-1:0]       i_out_ready,
   output logic [(2**SEL_W)*WIDTH-1:0] o_out_data
);

   localparam int N = 2**SEL_W;

   logic [N-1:0]            r_slotValid;
   logic [N-1:0][WIDTH-1:0] r_slotData;
   logic [N-1:0]            w_slotFree;
   logic [N-1:0]            w_slotWrite;
   logic                    w_accept;

   // A slot is free when empty or when its consumer takes the word this cycle,
   // so a draining slot can be refilled without a bubble.
   always_comb begin
      w_slotFree = ~r_slotValid | i_out_ready;
   end

   // Input ready and per-slot write enables; ready never looks at i_in_valid.
   always_comb begin
      o_in_ready  = 1'b0;
      w_slotWrite = '0;
      w_accept    = 1'b0;
`ifdef DEMUX_BCAST_EN
      if (i_in_bcast) begin
         o_in_ready = &w_slotFree;
         w_accept   = i_in_valid && o_in_ready;
         if (w_accept) begin
            w_slotWrite = '1;
         end
      end else begin
         o_in_ready = w_slotFree[i_in_sel];
         w_accept   = i_in_valid && o_in_ready;
         if (w_accept) begin
            w_slotWrite[i_in_sel] = 1'b1;
         end
      end
`else
      o_in_ready = w_slotFree[i_in_sel];
      w_accept   = i_in_valid && o_in_ready;
      if (w_accept) begin
         w_slotWrite[i_in_sel] = 1'b1;
      end
`endif
   end

   // Slot registers: a write wins over a drain so the channel stays full,
   // a drain alone clears valid and leaves the data untouched.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_slotValid <= '0;
         r_slotData  <= '0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (w_slotWrite[k]) begin
               r_slotValid[k] <= 1'b1;
               r_slotData[k]  <= i_in_data;
            end else if (r_slotValid[k] && i_out_ready[k]) begin
               r_slotValid[k] <= 1'b0;
            end
         end
      end
   end

   // Outputs come straight from the slot registers.
   always_comb begin
      o_out_valid = r_slotValid;
      o_out_data  = r_slotData;
   end

endmodule
